// File: rtl/mux4_rr_arbiter_pkg.sv
// ============================================================================
// mux_pkg : shared types and constants for the 4-way round-robin mux arbiter
// Revision: 1.0
// ============================================================================
`default_nettype none

package mux_pkg;

  localparam int NUM_REQ = 4;
  localparam int SEL_W   = 2;
  localparam int CNT_W   = 8;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

endpackage

`default_nettype wire

// File: rtl/mux4_rr_arbiter_rr_pick4.sv
// ============================================================================
// rr_pick4 : combinational rotating-priority picker (first set bit from ptr)
// Revision: 1.0
// ============================================================================
`default_nettype none

module rr_pick4
  import mux_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic [SEL_W-1:0]   ptr,
  output logic [SEL_W-1:0]   idx,
  output logic               any
);

  logic [SEL_W-1:0] w_k;

  // Scan from the farthest slot back to ptr so the closest set bit wins.
  always_comb begin
    idx = '0;
    w_k = '0;
    any = |req;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      w_k = ptr + SEL_W'(i);
      if (req[w_k]) begin
        idx = w_k;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/mux4_rr_arbiter.sv
// ============================================================================
// mux4_rr_arbiter : round-robin arbiter with burst limit steering a 4:1 mux
// Revision: 1.0
// ============================================================================
`default_nettype none

module mux4_rr_arbiter
  import mux_pkg::*;
#(
  parameter int DATA_W   = 1,
  parameter int MAX_HOLD = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  input  logic [DATA_W-1:0]  i0,
  input  logic [DATA_W-1:0]  i1,
  input  logic [DATA_W-1:0]  i2,
  input  logic [DATA_W-1:0]  i3,
  output logic [NUM_REQ-1:0] gnt,
  output logic               s1,
  output logic               s0,
  output logic               valid,
  output logic [DATA_W-1:0]  out
);

  localparam logic [CNT_W-1:0] C_HOLD_LAST = CNT_W'(MAX_HOLD - 1);

  state_t             r_state;
  logic [SEL_W-1:0]   r_ptr;
  logic [SEL_W-1:0]   r_sel;
  logic [CNT_W-1:0]   r_cnt;
  logic [NUM_REQ-1:0] r_gnt;

  logic [NUM_REQ-1:0] w_others;
  logic               w_at_limit;
  logic               w_release;
  logic [NUM_REQ-1:0] w_pick_req;
  logic [SEL_W-1:0]   w_pick_ptr;
  logic [SEL_W-1:0]   w_pick_idx;
  logic               w_pick_any;

  assign w_others   = req & ~(NUM_REQ'(1) << r_sel);
  assign w_at_limit = (r_cnt == C_HOLD_LAST);
  assign w_release  = !req[r_sel] || (w_at_limit && (|w_others));

  // One picker serves both cases; on handoff the owner is masked out and the
  // scan starts just past it, which is where ptr lands on release.
  assign w_pick_req = (r_state == GRANT) ? w_others : req;
  assign w_pick_ptr = (r_state == GRANT) ? (r_sel + SEL_W'(1)) : r_ptr;

  rr_pick4 u_pick (
    .req (w_pick_req),
    .ptr (w_pick_ptr),
    .idx (w_pick_idx),
    .any (w_pick_any)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_ptr   <= '0;
      r_cnt   <= '0;
      r_gnt   <= '0;
      r_sel   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_pick_any) begin
            r_gnt   <= NUM_REQ'(1) << w_pick_idx;
            r_sel   <= w_pick_idx;
            r_cnt   <= '0;
            r_state <= GRANT;
          end
        end
        GRANT: begin
          if (w_release) begin
            r_ptr <= r_sel + SEL_W'(1);
            r_cnt <= '0;
            if (w_pick_any) begin
              r_gnt <= NUM_REQ'(1) << w_pick_idx;
              r_sel <= w_pick_idx;
            end else begin
              r_gnt   <= '0;
              r_state <= IDLE;
            end
          end else if (w_at_limit) begin
            r_cnt <= '0;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        default: begin
          r_state <= IDLE;
          r_gnt   <= '0;
        end
      endcase
    end
  end

  assign gnt   = r_gnt;
  assign s1    = r_sel[1];
  assign s0    = r_sel[0];
  assign valid = |(r_gnt & req);

  always_comb begin
    out = '0;
    if (valid) begin
      case (r_sel)
        2'd0:    out = i0;
        2'd1:    out = i1;
        2'd2:    out = i2;
        default: out = i3;
      endcase
    end
  end

endmodule

`default_nettype wire
